// File: rtl/bp_be_issue_queue.sv
// Speculative issue queue: entries are enqueued at wptr, issued (read) at
// rptr and retired (committed) at cptr. Issued-but-uncommitted entries stay
// resident so a replay can rewind rptr back to the commit point.
//
// Handshakes:
//   enqueue : a write happens on a rising edge where v_i & ready_o & ~clr_i.
//             ready_o depends only on registered state, never on inputs.
//   issue   : data_o is valid while v_o; yumi_i (only while v_o) consumes it.
//   commit  : deq_i (only while issued entries are pending) frees one slot.
//   control : clr_i > roll_i > yumi_i; deq_i applies before a roll rewind.
module bp_be_issue_queue #(
   parameter int els_p   = 8,
   parameter int width_p = 64
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [width_p-1:0]       data_i,
   input  logic                     v_i,
   output logic                     ready_o,
   output logic [width_p-1:0]       data_o,
   output logic                     v_o,
   input  logic                     yumi_i,
   input  logic                     deq_i,
   input  logic                     roll_i,
   input  logic                     clr_i,
   output logic [$clog2(els_p):0]   count_o
);

   localparam int idx_w = $clog2(els_p);
   localparam int ptr_w = idx_w + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ptr_w-1:0]   wptr_r, rptr_r, cptr_r;
   logic [ptr_w-1:0]   wptr_n, rptr_n, cptr_n;
   logic [ptr_w-1:0]   cptr_deq;
   logic [width_p-1:0] mem [els_p];
   logic               full;
   logic               enq;

   assign full    = (wptr_r[idx_w-1:0] == cptr_r[idx_w-1:0])
                 && (wptr_r[idx_w] != cptr_r[idx_w]);
   assign ready_o = ~full;
   assign v_o     = (rptr_r != wptr_r);
   assign count_o = wptr_r - cptr_r;
   assign data_o  = mem[rptr_r[idx_w-1:0]];
   assign enq     = v_i & ready_o & ~clr_i;

   // Next-pointer selection with clr > roll > yumi priority.
   always_comb begin
      cptr_deq = cptr_r + ptr_w'(deq_i);
      wptr_n   = wptr_r + ptr_w'(enq);
      rptr_n   = rptr_r + ptr_w'(yumi_i);
      cptr_n   = cptr_deq;
      if (clr_i) begin
         wptr_n = wptr_r;
         rptr_n = wptr_r;
         cptr_n = wptr_r;
      end else if (roll_i) begin
         rptr_n = cptr_deq;
      end
   end

   // Pointer registers; reset discards every entry.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cptr_r <= '0;
      end else begin
         wptr_r <= wptr_n;
         rptr_r <= rptr_n;
         cptr_r <= cptr_n;
      end
   end

   // Storage write port; the array itself is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i && enq) begin
         mem[wptr_r[idx_w-1:0]] <= data_i;
      end
   end

   // Flags illegal issue/commit requests from the surrounding pipeline.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(yumi_i && !v_o && !clr_i && !roll_i));
         assert (!(deq_i && (cptr_r == rptr_r) && !clr_i));
      end
   end

endmodule
